alu_cmd_driver: RTL and testbench

Initiator for the byte-serial ALU command port (ctl/dat in, result/ready out) implemented by alu_math. Accepts one parallel request (opcode plus two 16-bit operands), serializes it onto the ALU's ctl/dat bus, waits for the ALU's ready pulse, and returns the 32-bit result on a valid/ready response channel. Sits between the system-side request logic and the ALU instance; one command in flight at a time.

---
 rtl/alu_cmd_driver.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Byte-serial command initiator for alu_math: serializes one request, awaits alu_ready, returns result.
// Optional WAIT timeout (status 2) is built only when ALU_DRV_TIMEOUT_EN is defined.
module alu_cmd_driver #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_status,
   output logic        alu_ctl,
   output logic [7:0]  alu_dat,
   input  logic [31:0] alu_result,
   input  logic        alu_ready
);

   localparam logic [3:0] OpIncA   = 4'd6;
   localparam logic [3:0] OpIncB   = 4'd7;
   localparam logic [3:0] OpClrRes = 4'd8;
   localparam logic [3:0] OpAccum  = 4'd9;

   typedef enum logic [2:0] {
      StIdle, StOpc, StAMsb, StALsb, StBMsb, StBLsb, StWait, StResp
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic [31:0] result_q, result_d;
   logic [1:0]  status_q, status_d;
   logic        req_ready_q, rsp_valid_q, alu_ctl_q;
   logic [7:0]  alu_dat_q, alu_dat_d;
`ifdef ALU_DRV_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      status_d = status_q;
`ifdef ALU_DRV_TIMEOUT_EN
      cnt_d    = '0;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d     = req_op;
               a_d      = req_a;
               b_d      = req_b;
               result_d = '0;
               if (req_op > OpAccum) begin
                  status_d = 2'd1;
                  state_d  = StResp;
               end else begin
                  status_d = 2'd0;
                  state_d  = StOpc;
               end
            end
         end
         StOpc: begin
            if (op_q == OpClrRes)    state_d = StWait;
            else if (op_q == OpIncB) state_d = StBMsb;
            else                     state_d = StAMsb;
         end
         StAMsb: state_d = StALsb;
         StALsb: state_d = ((op_q == OpIncA) || (op_q == OpAccum)) ? StWait : StBMsb;
         StBMsb: state_d = StBLsb;
         StBLsb: state_d = StWait;
         StWait: begin
            // A completion in the last counted cycle beats the timeout.
            if (alu_ready) begin
               result_d = alu_result;
               status_d = 2'd0;
               state_d  = StResp;
            end
`ifdef ALU_DRV_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT - 1)) begin
               result_d = '0;
               status_d = 2'd2;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         StResp: begin
            if (rsp_ready) begin
               result_d = '0;
               status_d = '0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with state_q.
   always_comb begin
      alu_dat_d = '0;
      unique case (state_d)
         StOpc:   alu_dat_d = {4'h0, op_d};
         StAMsb:  alu_dat_d = a_d[15:8];
         StALsb:  alu_dat_d = a_d[7:0];
         StBMsb:  alu_dat_d = b_d[15:8];
         StBLsb:  alu_dat_d = b_d[7:0];
         default: alu_dat_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         status_q    <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         alu_ctl_q   <= 1'b0;
         alu_dat_q   <= '0;
`ifdef ALU_DRV_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         status_q    <= status_d;
         req_ready_q <= (state_d == StIdle);
         rsp_valid_q <= (state_d == StResp);
         alu_ctl_q   <= (state_d == StOpc);
         alu_dat_q   <= alu_dat_d;
`ifdef ALU_DRV_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = result_q;
   assign rsp_status = status_q;
   assign alu_ctl    = alu_ctl_q;
   assign alu_dat    = alu_dat_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver: the bench plays the ALU and checks bus bytes and responses.
module tb_alu_cmd_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_status;
   logic        alu_ctl;
   logic [7:0]  alu_dat;
   logic [31:0] alu_result = '0;
   logic        alu_ready = 1'b0;

   always #5 clk = ~clk;

   alu_cmd_driver #(
      .TIMEOUT (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_status (rsp_status),
      .alu_ctl    (alu_ctl),
      .alu_dat    (alu_dat),
      .alu_result (alu_result),
      .alu_ready  (alu_ready)
   );

`ifdef ALU_DRV_TIMEOUT_EN
   localparam int DMax = 7;
`else
   localparam int DMax = 12;
`endif

   typedef struct packed {
      logic [39:0] bytes;
      logic [2:0]  n;
      logic [31:0] res;
      logic [7:0]  dly;
      logic        early;
   } plan_t;

   typedef struct packed {
      logic [31:0] res;
      logic [1:0]  st;
   } rsp_t;

   plan_t plan_q[$];
   rsp_t  rsp_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 1'b1;
   bit    rr_rand = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // ALU side: checks every bus cycle against the expected byte stream and answers with alu_ready.
   plan_t cur;
   int    ph = 0;
   int    idx = 0;
   int    wcnt = 0;
   bit    chk_rv = 1'b0;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         alu_ready = 1'b0;
         if (chk_rv) begin
            chk("rsp_after_alu_ready", 32'(rsp_valid), 32'd1);
            chk_rv = 1'b0;
         end
         case (ph)
            0: begin
               if (alu_ctl) begin
                  if (plan_q.size() == 0) begin
                     chk("unexpected_ctl", 32'(alu_ctl), 32'd0);
                  end else begin
                     cur = plan_q.pop_front();
                     chk("opcode_byte", 32'(alu_dat), 32'(cur.bytes[7:0]));
                     idx  = 1;
                     wcnt = 0;
                     ph   = (cur.n == 3'd1) ? 2 : 1;
                     // Spurious completion outside WAIT must be ignored.
                     if (cur.early) begin
                        alu_ready  = 1'b1;
                        alu_result = $urandom;
                     end
                  end
               end else begin
                  chk("idle_bus", 32'({alu_ctl, alu_dat}), 32'd0);
               end
            end
            1: begin
               chk("operand_byte", 32'({alu_ctl, alu_dat}), 32'({1'b0, cur.bytes[8*idx +: 8]}));
               idx++;
               if (idx == int'(cur.n)) ph = 2;
            end
            default: begin
               chk("wait_bus", 32'({alu_ctl, alu_dat}), 32'd0);
               if (wcnt == int'(cur.dly)) begin
                  alu_ready  = 1'b1;
                  alu_result = cur.res;
                  chk_rv     = 1'b1;
                  ph         = 0;
               end else begin
                  wcnt++;
               end
            end
         endcase
      end
   end

   // Response monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
   bit          hold = 1'b0;
   logic [31:0] held_res;
   logic [1:0]  held_st;

   always @(negedge clk) begin
      rsp_t r;
      if (mon_en && !rst) begin
         if (hold) begin
            chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_hold_result", rsp_result, held_res);
            chk("rsp_hold_status", 32'(rsp_status), 32'(held_st));
         end
         hold     = rsp_valid && !rsp_ready;
         held_res = rsp_result;
         held_st  = rsp_status;
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_result", rsp_result, r.res);
               chk("rsp_status", 32'(rsp_status), 32'(r.st));
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int w = 0;
      while (!req_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'(req_ready), 32'd1);
         finish_sim();
      end
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Reference: opcode byte, then A if the op reads A, then B if it reads B.
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] res, input int dly, input bit early);
      plan_t      p;
      rsp_t       r;
      logic [7:0] q[$];
      if (op <= 4'd9) begin
         q.push_back({4'h0, op});
         if (op != 4'd7 && op != 4'd8) begin
            q.push_back(a[15:8]);
            q.push_back(a[7:0]);
         end
         if (!(op inside {4'd6, 4'd8, 4'd9})) begin
            q.push_back(b[15:8]);
            q.push_back(b[7:0]);
         end
         p.bytes = '0;
         foreach (q[i]) p.bytes[8*i +: 8] = q[i];
         p.n     = 3'(q.size());
         p.res   = res;
         p.dly   = 8'(dly);
         p.early = early;
         plan_q.push_back(p);
         r.res = res;
         r.st  = 2'd0;
      end else begin
         r.res = '0;
         r.st  = 2'd1;
      end
      rsp_q.push_back(r);
      send(op, a, b);
      if (op > 4'd9) begin
         chk("illegal_rsp_latency", 32'(rsp_valid), 32'd1);
         chk("illegal_no_ctl", 32'(alu_ctl), 32'd0);
      end else begin
         chk("busy_after_accept", 32'(req_ready), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      chk("watchdog", 32'd1, 32'd0);
      finish_sim();
   end

   initial begin
      logic [3:0] op;
      int         w;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_outputs", 32'({rsp_valid, rsp_status, alu_ctl, alu_dat}), 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("req_ready_after_rst", 32'(req_ready), 32'd1);

      issue(4'd0, 16'h0003, 16'h0004, 32'h0000_0007, 0, 1'b0);
      issue(4'd7, 16'h5A5A, 16'h00FF, 32'h0000_0201, 2, 1'b1);
      issue(4'd8, 16'h1111, 16'h2222, 32'h0000_0000, 1, 1'b1);
      issue(4'hA, 16'h1234, 16'h5678, 32'h0, 0, 1'b0);
      issue(4'd9, 16'hBEEF, 16'h0000, 32'hCAFE_F00D, DMax, 1'b0);

      for (int i = 0; i < 60; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         issue(op, 16'($urandom), 16'($urandom), $urandom, $urandom_range(0, DMax),
               1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      w = 0;
      while ((rsp_q.size() != 0 || ph != 0) && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard_drained", 32'(rsp_q.size()), 32'd0);
      repeat (2) @(negedge clk);

      mon_en    = 1'b0;
      rr_rand   = 1'b0;
      rsp_ready = 1'b0;
      alu_ready = 1'b0;
      repeat (2) @(negedge clk);

`ifdef ALU_DRV_TIMEOUT_EN
      // WAIT entered at E+6; timeout response due at E+14.
      send(4'd0, 16'h0001, 16'h0002);
      for (int k = 1; k <= 14; k++) begin
         chk("timeout_valid", 32'(rsp_valid), (k == 14) ? 32'd1 : 32'd0);
         if (k < 14) @(negedge clk);
      end
      chk("timeout_status", 32'(rsp_status), 32'd2);
      chk("timeout_result", rsp_result, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("timeout_release", 32'({rsp_valid, req_ready}), 32'b01);
`else
      send(4'd0, 16'h0001, 16'h0002);
      w = 0;
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid || req_ready) w++;
         @(negedge clk);
      end
      chk("no_timeout_stall", 32'(w), 32'd0);
      alu_ready  = 1'b1;
      alu_result = 32'h0000_0033;
      @(negedge clk);
      alu_ready = 1'b0;
      chk("late_ready_status", 32'({rsp_valid, rsp_status}), 32'b100);
      chk("late_ready_result", rsp_result, 32'h0000_0033);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
`endif

      // Abort mid-command during B_MSB.
      send(4'd0, 16'h1111, 16'h1234);
      repeat (3) @(negedge clk);
      chk("b_msb_byte", 32'(alu_dat), 32'h12);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_outputs", 32'({alu_ctl, alu_dat, rsp_valid, req_ready}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("req_ready_after_mid_rst", 32'(req_ready), 32'd1);

      // MUL with the consumer stalling for five cycles.
      send(4'd3, 16'h0010, 16'h0010);
      repeat (5) @(negedge clk);
      alu_ready  = 1'b1;
      alu_result = 32'h0000_0100;
      @(negedge clk);
      alu_ready = 1'b0;
      chk("mul_valid", 32'(rsp_valid), 32'd1);
      chk("mul_result", rsp_result, 32'h0000_0100);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("mul_stall", 32'({rsp_valid, rsp_status}), 32'b100);
         chk("mul_stall_result", rsp_result, 32'h0000_0100);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("mul_release", 32'({rsp_valid, req_ready}), 32'b01);

      finish_sim();
   end

endmodule
